// File: rtl/cheshire_soc_fixture_if.sv
// Run-control bus between the Cheshire SoC harness and cheshire_soc_fixture.
// The harness drives the mode straps, the core 0 commit port and the EOC
// scratch-register write strobe. The fixture returns the completion status.
// Handshake: eoc_we_i qualifies eoc_wdata_i for exactly the cycle it is high.
// There is no backpressure, so the fixture samples every strobed write on
// the rising clock edge. commit_ack_i qualifies commit_pc_i in the same way.
interface cheshire_soc_fixture_if #(
    parameter int PC_WIDTH = 64
);
    logic [1:0]          boot_mode_i;
    logic [1:0]          preload_mode_i;
    logic                commit_ack_i;
    logic [PC_WIDTH-1:0] commit_pc_i;
    logic                eoc_we_i;
    logic [31:0]         eoc_wdata_i;
    logic [1:0]          channel_o;
    logic                cfg_err_o;
    logic                eoc_o;
    logic [31:0]         exit_code_o;
    logic                hang_o;
    logic [PC_WIDTH-1:0] hang_pc_o;
    logic                finish_o;
    logic [2:0]          dbg_state;

    modport master (
        output boot_mode_i, preload_mode_i, commit_ack_i, commit_pc_i,
               eoc_we_i, eoc_wdata_i,
        input  channel_o, cfg_err_o, eoc_o, exit_code_o, hang_o, hang_pc_o,
               finish_o, dbg_state
    );

    modport slave (
        input  boot_mode_i, preload_mode_i, commit_ack_i, commit_pc_i,
               eoc_we_i, eoc_wdata_i,
        output channel_o, cfg_err_o, eoc_o, exit_code_o, hang_o, hang_pc_o,
               finish_o, dbg_state
    );
endinterface

// File: rtl/cheshire_soc_fixture.sv
// Run-control fixture around the Cheshire SoC. It latches the boot and preload
// modes when reset is released, selects the completion channel, captures the
// EOC exit code and raises a sticky finish request.
// Optional macro CHESHIRE_FIXTURE_HANG_WATCHDOG_EN builds the commit-PC hang
// watchdog together with the HANG/FIN grace sequence. Without the macro,
// hang_o and hang_pc_o are tied low.
module cheshire_soc_fixture #(
    parameter int PC_WIDTH     = 64,
    parameter int MAX_CYCLES   = 10000,
    parameter int GRACE_CYCLES = 100
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    cheshire_soc_fixture_if.slave bus
);
    localparam logic [2:0] ST_CFG  = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_HANG = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    logic [2:0]  state;
    logic [1:0]  channel;
    logic        cfg_err;
    logic        eoc;
    logic [31:0] exit_code;
    logic        finish;
    logic        eoc_hit;
    logic        hang_hit;
    logic        grace_done;

    // EOC writes are only honoured while software can still complete the run.
    // Leaving RUN/HANG on the first hit makes capture first-write-only.
    assign eoc_hit = bus.eoc_we_i && bus.eoc_wdata_i[0] &&
                     ((state == ST_RUN) || (state == ST_HANG));

`ifdef CHESHIRE_FIXTURE_HANG_WATCHDOG_EN
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int GW = $clog2(GRACE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_CYCLES - 1);
    localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYCLES - 1);

    logic                armed;
    logic                armed_now;
    logic                pc_same;
    logic [PC_WIDTH-1:0] old_pc;
    logic [CW-1:0]       count;
    logic [GW-1:0]       grace;
    logic                hang;
    logic [PC_WIDTH-1:0] hang_pc;

    // The acknowledge that arms the watchdog already takes part in counting.
    assign armed_now  = armed || bus.commit_ack_i;
    assign pc_same    = (bus.commit_pc_i == old_pc);
    // The threshold is hit on the edge where the count would reach MAX_CYCLES.
    // An EOC on that same edge takes priority.
    assign hang_hit   = (state == ST_RUN) && armed_now && pc_same &&
                        (count >= CNT_LAST) && !eoc_hit;
    assign grace_done = (state == ST_HANG) && (grace == GRACE_LAST);

    // Watchdog: track the commit PC while in RUN and time the grace window in HANG.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            armed   <= 1'b0;
            old_pc  <= '0;
            count   <= '0;
            grace   <= '0;
            hang    <= 1'b0;
            hang_pc <= '0;
        end else if (state == ST_RUN) begin
            if (bus.commit_ack_i) begin
                armed <= 1'b1;
            end
            if (armed_now) begin
                if (pc_same) begin
                    if (count != CNT_MAX) begin
                        count <= count + CW'(1);
                    end
                end else begin
                    old_pc <= bus.commit_pc_i;
                    count  <= '0;
                end
            end
            if (hang_hit) begin
                hang    <= 1'b1;
                hang_pc <= bus.commit_pc_i;
            end
        end else if ((state == ST_HANG) && !eoc_hit && !grace_done) begin
            grace <= grace + GW'(1);
        end
    end

    assign bus.hang_o    = hang;
    assign bus.hang_pc_o = hang_pc;
`else
    logic unused_commit;

    assign hang_hit      = 1'b0;
    assign grace_done    = 1'b0;
    assign unused_commit = ^{bus.commit_ack_i, bus.commit_pc_i};
    assign bus.hang_o    = 1'b0;
    assign bus.hang_pc_o = '0;
`endif

    // Run-control FSM: decode the modes once, then wait for EOC, error or hang.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_CFG;
            channel   <= 2'd0;
            cfg_err   <= 1'b0;
            eoc       <= 1'b0;
            exit_code <= '0;
            finish    <= 1'b0;
        end else begin
            case (state)
                ST_CFG: begin
                    if ((bus.boot_mode_i == 2'd1) ||
                        ((bus.boot_mode_i == 2'd0) && (bus.preload_mode_i == 2'd3))) begin
                        state <= ST_ERR;
                    end else begin
                        channel <= (bus.boot_mode_i == 2'd0) ? bus.preload_mode_i : 2'd0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN, ST_HANG: begin
                    if (eoc_hit) begin
                        exit_code <= {1'b0, bus.eoc_wdata_i[31:1]};
                        eoc       <= 1'b1;
                        state     <= ST_DONE;
                    end else if (hang_hit) begin
                        state <= ST_HANG;
                    end else if (grace_done) begin
                        finish <= 1'b1;
                        state  <= ST_FIN;
                    end
                end
                ST_DONE: begin
                    finish <= 1'b1;
                end
                ST_ERR: begin
                    cfg_err <= 1'b1;
                    finish  <= 1'b1;
                end
                ST_FIN: begin
                    finish <= 1'b1;
                end
                default: begin
                    state <= ST_CFG;
                end
            endcase
        end
    end

    assign bus.channel_o   = channel;
    assign bus.cfg_err_o   = cfg_err;
    assign bus.eoc_o       = eoc;
    assign bus.exit_code_o = exit_code;
    assign bus.finish_o    = finish;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_cheshire_soc_fixture.sv
// Self-checking bench for cheshire_soc_fixture. It runs table vectors,
// hand-written watchdog sequences and randomized runs against a rule-level model.
module tb_cheshire_soc_fixture;
    localparam int PC_WIDTH     = 64;
    localparam int MAX_CYCLES   = 10000;
    localparam int GRACE_CYCLES = 100;
    localparam int W            = 38;
`ifdef CHESHIRE_FIXTURE_HANG_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif
    localparam logic [63:0] HANG_PC = 64'h0000_0000_8000_1000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cheshire_soc_fixture_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    cheshire_soc_fixture #(
        .PC_WIDTH(PC_WIDTH), .MAX_CYCLES(MAX_CYCLES), .GRACE_CYCLES(GRACE_CYCLES)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ch, input logic err,
                              input logic eoc, input logic [31:0] exitc,
                              input logic hang, input logic fin);
        check({tag, ".channel"}, 64'(bus.channel_o), 64'(ch));
        check({tag, ".cfg_err"}, 64'(bus.cfg_err_o), 64'(err));
        check({tag, ".eoc"}, 64'(bus.eoc_o), 64'(eoc));
        check({tag, ".exit_code"}, 64'(bus.exit_code_o), 64'(exitc));
        check({tag, ".hang"}, 64'(bus.hang_o), 64'(hang));
        check({tag, ".finish"}, 64'(bus.finish_o), 64'(fin));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_idle();
        bus.commit_ack_i = 1'b0;
        bus.commit_pc_i  = '0;
        bus.eoc_we_i     = 1'b0;
        bus.eoc_wdata_i  = '0;
    endtask

    // Returns just after the configuration edge. The mode straps are then
    // scrambled, so the DUT must rely on its latched copy.
    task automatic reset_run(input logic [1:0] boot, input logic [1:0] pre);
        rst_n = 1'b0;
        bus.boot_mode_i    = boot;
        bus.preload_mode_i = pre;
        drive_idle();
        step(2);
        rst_n = 1'b1;
        step(1);
        bus.boot_mode_i    = ~boot;
        bus.preload_mode_i = ~pre;
    endtask

    task automatic eoc_write(input logic [31:0] w);
        bus.eoc_we_i    = 1'b1;
        bus.eoc_wdata_i = w;
        step(1);
        bus.eoc_we_i    = 1'b0;
    endtask

    // One acknowledge pulse captures pc, then pc is held for n more cycles.
    task automatic arm_and_hold(input logic [63:0] pc, input int n);
        bus.commit_ack_i = 1'b1;
        bus.commit_pc_i  = pc;
        step(1);
        bus.commit_ack_i = 1'b0;
        step(n);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  boot;
        logic [1:0]  pre;
        logic [31:0] wdata;
        logic [1:0]  exp_ch;
        logic        exp_err;
        logic        exp_eoc;
        logic [31:0] exp_exit;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd0, 2'd2, 32'h0000_0001, 2'd2, 1'b0, 1'b1, 32'h0000_0000};
        vecs[1] = '{2'd0, 2'd0, 32'h0000_0055, 2'd0, 1'b0, 1'b1, 32'h0000_002A};
        vecs[2] = '{2'd1, 2'd0, 32'h0000_0001, 2'd0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[3] = '{2'd0, 2'd3, 32'h0000_0001, 2'd0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[4] = '{2'd2, 2'd1, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b1, 32'h7FFF_FFFF};
        vecs[5] = '{2'd3, 2'd2, 32'h0000_0002, 2'd0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6] = '{2'd0, 2'd1, 32'h8000_0001, 2'd1, 1'b0, 1'b1, 32'h4000_0000};
        vecs[7] = '{2'd1, 2'd3, 32'h0000_0003, 2'd0, 1'b1, 1'b0, 32'h0000_0000};

        bus.boot_mode_i    = 2'd0;
        bus.preload_mode_i = 2'd0;
        drive_idle();

        // Reset state.
        step(2);
        check_outs("reset", 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("reset.hang_pc", bus.hang_pc_o, 64'd0);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            reset_run(vecs[i].boot, vecs[i].pre);
            step(1);
            eoc_write(vecs[i].wdata);
            step(1);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ch, vecs[i].exp_err,
                       vecs[i].exp_eoc, vecs[i].exp_exit, 1'b0,
                       vecs[i].exp_err | vecs[i].exp_eoc);
        end

        // Error flags within two cycles of reset release.
        reset_run(2'd1, 2'd0);
        check("err_early.cfg_err", 64'(bus.cfg_err_o), 64'd0);
        step(1);
        check("err_fast.cfg_err", 64'(bus.cfg_err_o), 64'd1);
        check("err_fast.finish", 64'(bus.finish_o), 64'd1);

        // Finish follows EOC by one cycle. Only the first valid write is kept.
        reset_run(2'd0, 2'd0);
        eoc_write(32'h0000_0055);
        check("eoc1.finish_same_cycle", 64'(bus.finish_o), 64'd0);
        check("eoc1.exit", 64'(bus.exit_code_o), 64'h2A);
        eoc_write(32'h0000_0003);
        check("eoc2.exit_kept", 64'(bus.exit_code_o), 64'h2A);
        check("eoc2.finish", 64'(bus.finish_o), 64'd1);

        // Hang: threshold, then the grace window, then frozen.
        reset_run(2'd3, 2'd0);
        arm_and_hold(HANG_PC, MAX_CYCLES - 1);
        check("hang.before", 64'(bus.hang_o), 64'd0);
        step(1);
        check("hang.fired", 64'(bus.hang_o), 64'(WD_EN));
        check("hang.pc", bus.hang_pc_o, WD_EN ? HANG_PC : 64'd0);
        check("hang.channel", 64'(bus.channel_o), 64'd0);
        step(GRACE_CYCLES - 1);
        check("hang.grace_finish_low", 64'(bus.finish_o), 64'd0);
        step(1);
        check("hang.finish", 64'(bus.finish_o), 64'(WD_EN));
        bus.commit_pc_i = 64'h1234;
        step(5);
        check("hang.frozen_pc", bus.hang_pc_o, WD_EN ? HANG_PC : 64'd0);
        check("hang.frozen_finish", 64'(bus.finish_o), 64'(WD_EN));

        // Reset mid-run clears everything, and the next run re-latches the modes.
        rst_n = 1'b0;
        step(1);
        check_outs("midreset", 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("midreset.hang_pc", bus.hang_pc_o, 64'd0);
        reset_run(2'd0, 2'd1);
        check("relatch.channel", 64'(bus.channel_o), 64'd1);

        // EOC on the exact threshold cycle wins over the hang.
        reset_run(2'd2, 2'd0);
        arm_and_hold(HANG_PC, MAX_CYCLES - 1);
        eoc_write(32'h0000_0007);
        check("tie.eoc", 64'(bus.eoc_o), 64'd1);
        check("tie.exit", 64'(bus.exit_code_o), 64'd3);
        check("tie.hang", 64'(bus.hang_o), 64'd0);
        step(1);
        check("tie.finish", 64'(bus.finish_o), 64'd1);
        step(GRACE_CYCLES + 10);
        check("tie.hang_later", 64'(bus.hang_o), 64'd0);

        // EOC during the grace window.
        reset_run(2'd3, 2'd0);
        arm_and_hold(HANG_PC, MAX_CYCLES);
        step(10);
        eoc_write(32'h0000_0011);
        check("grace_eoc.eoc", 64'(bus.eoc_o), 64'd1);
        check("grace_eoc.exit", 64'(bus.exit_code_o), 64'd8);
        check("grace_eoc.hang", 64'(bus.hang_o), 64'(WD_EN));
        step(1);
        check("grace_eoc.finish", 64'(bus.finish_o), 64'd1);
        step(GRACE_CYCLES + 20);
        check("grace_eoc.exit_kept", 64'(bus.exit_code_o), 64'd8);

        // A PC that toggles every 50 cycles never looks hung.
        reset_run(2'd0, 2'd0);
        bus.commit_ack_i = 1'b1;
        for (int i = 0; i < 210; i++) begin
            bus.commit_pc_i = (i % 2 == 0) ? HANG_PC : 64'h0000_0000_8000_2000;
            step(50);
            bus.commit_ack_i = 1'b0;
        end
        check("toggle.hang", 64'(bus.hang_o), 64'd0);
        check("toggle.finish", 64'(bus.finish_o), 64'd0);

        // Randomized short runs against the rule-level model.
        for (int r = 0; r < 25; r++) begin
            logic [1:0]  boot;
            logic [1:0]  pre;
            logic        m_err;
            logic [1:0]  m_ch;
            logic        m_eoc;
            logic [31:0] m_exit;
            int          m_eoc_t;
            logic        m_fin;
            logic        we;
            logic [31:0] wd;
            logic [W-1:0] got;
            logic [W-1:0] exp;
            boot   = 2'($urandom_range(0, 3));
            pre    = 2'($urandom_range(0, 3));
            m_err  = (boot == 2'd1) || (boot == 2'd0 && pre == 2'd3);
            m_ch   = m_err ? 2'd0 : ((boot == 2'd0) ? pre : 2'd0);
            m_eoc  = 1'b0;
            m_exit = '0;
            m_eoc_t = 0;
            reset_run(boot, pre);
            for (int t = 2; t < 42; t++) begin
                we = ($urandom_range(0, 3) == 0);
                wd = $urandom;
                bus.eoc_we_i       = we;
                bus.eoc_wdata_i    = wd;
                bus.commit_ack_i   = 1'($urandom_range(0, 1));
                bus.commit_pc_i    = {$urandom, $urandom};
                bus.boot_mode_i    = 2'($urandom_range(0, 3));
                bus.preload_mode_i = 2'($urandom_range(0, 3));
                if (!m_err && !m_eoc && we && wd[0]) begin
                    m_eoc   = 1'b1;
                    m_exit  = wd / 2;
                    m_eoc_t = t;
                end
                m_fin = m_err || (m_eoc && t > m_eoc_t);
                exp_q.push_back({m_ch, m_err, m_eoc, m_exit, m_fin, 1'b0});
                step(1);
                got = {bus.channel_o, bus.cfg_err_o, bus.eoc_o, bus.exit_code_o,
                       bus.finish_o, bus.hang_o};
                exp = exp_q.pop_front();
                check($sformatf("rand%0d.t%0d", r, t), 64'(got), 64'(exp));
            end
            drive_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
